uart_tx_fifo: RTL and testbench

Transmit-side buffer that sits directly upstream of the UART transmitter and drives its `d_in`/`wr_en` inputs. Software or an upstream block pushes bytes at any rate. The FIFO stores up to DEPTH bytes and releases them to the transmitter one at a time. The transmitter has no busy output, so releases are paced by an internal frame counter: successive `tx_en` pulses are never closer than FRAME_CYCLES clocks.

---
 rtl/uart_tx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter, releases paced one frame apart
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int FRAME_CYCLES = 10
) (
    input  logic                     tx_clk,
    input  logic                     rst_n,
    input  logic [7:0]               din,
    input  logic                     push,
    input  logic                     clr_ovf,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               tx_data,
    output logic                     tx_en
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(FRAME_CYCLES);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(FRAME_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    logic [7:0]    mem [DEPTH];

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_en_q, tx_en_d;

    logic          push_ok;
    logic          pop;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_data  = tx_data_q;
    assign tx_en    = tx_en_q;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign push_ok = push && !full;

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        rp_d      = rp_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    tx_data_d = mem[rp_q];
                    tx_en_d   = 1'b1;
                    rp_d      = rp_q + AW'(1);
                    gap_d     = GAP_LOAD;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                gap_d = gap_q - GW'(1);
                if (gap_q == GW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wp_d       = wp_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wp_d = wp_q + AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end
        // Set takes priority over clear so a drop is never lost.
        if (push && full) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (push_ok) begin
            mem[wp_q] <= din;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int FRAME = 10;

    logic       tx_clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       push;
    logic       clr_ovf;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_en;

    uart_tx_fifo #(.DEPTH(DEPTH), .FRAME_CYCLES(FRAME)) dut (
        .tx_clk   (tx_clk),
        .rst_n    (rst_n),
        .din      (din),
        .push     (push),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_en    (tx_en)
    );

    always #5 tx_clk = ~tx_clk;

    int cyc = 0;
    always @(posedge tx_clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         exp_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every tx_en pulse is matched against the oldest expected byte.
    int   last_pulse;
    bit   last_valid = 1'b0;
    exp_t e;
    always @(negedge tx_clk) begin
        if (!rst_n) begin
            last_valid = 1'b0;
        end else if (tx_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got tx_data %0h, expected no pulse (cycle %0d)", tx_data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("tx_data", int'(tx_data), int'(e.data));
                if (e.exp_cyc != 0) chk("pulse_cycle", cyc, e.exp_cyc);
            end
            if (last_valid) begin
                n_cmp++;
                if (cyc - last_pulse < FRAME) begin
                    n_bad++;
                    $display("FAIL pulse_spacing: got %0d cycles, expected >= %0d", cyc - last_pulse, FRAME);
                end
            end
            last_pulse = cyc;
            last_valid = 1'b1;
        end
    end

    task automatic step(input logic p, input logic [7:0] d, input logic c);
        push    = p;
        din     = d;
        clr_ovf = c;
        @(posedge tx_clk);
        @(negedge tx_clk);
        push    = 1'b0;
        clr_ovf = 1'b0;
    endtask

    // lat = cycles from the push edge to the expected pulse; 0 checks order only.
    task automatic send(input logic [7:0] d, input int lat);
        int edge_n;
        edge_n = cyc + 1;
        exp_q.push_back('{data: d, exp_cyc: (lat == 0) ? 0 : edge_n + lat});
        step(1'b1, d, 1'b0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !empty) && n < budget) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (12) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tx_en"},    int'(tx_en),    0);
        chk({tag, "_tx_data"},  int'(tx_data),  0);
        chk({tag, "_count"},    int'(count),    0);
        chk({tag, "_empty"},    int'(empty),    1);
        chk({tag, "_full"},     int'(full),     0);
        chk({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        push    = 1'b0;
        din     = 8'h00;
        clr_ovf = 1'b0;
        repeat (2) @(negedge tx_clk);
        check_reset("por");
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Single byte: count 0->1->0, one-cycle pulse one edge after the write.
        send(8'hA5, 1);
        chk("t1_count_push", int'(count), 1);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_count_pop", int'(count), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_tx_en_low", int'(tx_en), 0);
        chk("t1_empty", int'(empty), 1);
        drain(50);

        // Burst of four: pulses at +1, +11, +21, +31 from the first push edge.
        send(8'h01, 1);
        send(8'h02, 10);
        send(8'h03, 19);
        send(8'h04, 28);
        drain(100);

        // Pops land on edges k+1 and k+11, so 18 accepted pushes reach full.
        for (int j = 0; j < 18; j++) send(8'(8'h10 + j), 0);
        chk("t3_full", int'(full), 1);
        chk("t3_count16", int'(count), 16);
        chk("t3_ovf_clear", int'(overflow), 0);
        step(1'b1, 8'hEE, 1'b0);
        chk("t3_ovf_set", int'(overflow), 1);
        chk("t3_count_hold", int'(count), 16);
        step(1'b0, 8'h00, 1'b1);
        chk("t3_clr_ovf", int'(overflow), 0);
        step(1'b0, 8'h00, 1'b0);
        // Edge k+21 pops; the push on the same edge is still dropped.
        step(1'b1, 8'hDD, 1'b0);
        chk("t4_count15", int'(count), 15);
        chk("t4_ovf_set", int'(overflow), 1);
        chk("t4_not_full", int'(full), 0);
        step(1'b0, 8'h00, 1'b1);
        chk("t4_clr_ovf", int'(overflow), 0);
        drain(300);

        // Stream 40 bytes at the drain rate, crossing the pointer wrap.
        for (int i = 0; i < 40; i++) begin
            if (i >= 5) repeat (9) step(1'b0, 8'h00, 1'b0);
            send(8'(8'h40 + i), 0);
        end
        chk("t5_overflow", int'(overflow), 0);
        drain(300);

        // Reset three clocks into a gap with three bytes still queued.
        send(8'h61, 1);
        send(8'h62, 0);
        send(8'h63, 0);
        send(8'h64, 0);
        step(1'b0, 8'h00, 1'b0);
        chk("t6_count3", int'(count), 3);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        @(negedge tx_clk);
        @(negedge tx_clk);
        rst_n = 1'b1;
        send(8'h5A, 1);
        drain(40);

        chk("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
